demux_pipe: RTL and testbench

//  Inverse of the two-source merge stage: splits one 128-bit enq stream into two

---
 rtl/demux_pipe_pkg.sv | 26 ++
 rtl/demux_slot.sv | 32 +++
 rtl/demux_pipe.sv | 138 +++++++++++++
 tb/tb_demux_pipe.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pipe_pkg.sv
// Shared constants and types for the packet demultiplexer.
package demux_pipe_pkg;

    // Header destination codes; any code at or above DEST_DROP discards the packet.
    localparam logic [1:0] DEST_OUT  = 2'd0;
    localparam logic [1:0] DEST_FWD  = 2'd1;
    localparam logic [1:0] DEST_DROP = 2'd2;

    // Header field placement: LEN sits at the bottom, DEST directly above it.
    localparam int LEN_LSB   = 0;
    localparam int DEF_LEN_W = 16;
    localparam int DEST_LSB  = LEN_LSB + DEF_LEN_W;
    localparam int DEST_W    = 2;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } state_t;

    // True when a destination code means "discard the packet".
    function automatic logic is_drop(input logic [1:0] dest);
        return dest >= DEST_DROP;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slice. Holds a single beat for one consumer and
// can take a new beat in the same cycle the held beat is drained.
module demux_slot #(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              accept,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    input  logic              deq
);

    // Free when empty, or when the held beat leaves this cycle.
    assign accept = !valid || deq;

    // Load wins over drain so a simultaneous load/drain keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (deq) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_pipe.sv
// Splits one beat stream into a local and a forward output, or discards it,
// one packet at a time under control of a header beat.
//
// Handshake: a beat moves across an interface exactly in the cycle its ENA is
// high; ENA on an input is only raised while the matching RDY is high, and the
// RDY this block drives never looks at the incoming data.
module demux_pipe
    import demux_pipe_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_enq__ENA,
    input  logic [DATA_W-1:0] in_enq_v,
    output logic              in_enq__RDY,
    output logic              out_enq__ENA,
    output logic [DATA_W-1:0] out_enq_v,
    input  logic              out_enq__RDY,
    output logic              forward_enq__ENA,
    output logic [DATA_W-1:0] forward_enq_v,
    input  logic              forward_enq__RDY,
    output logic [CNT_W-1:0]  dropCount,
    output logic [1:0]        dbg_state
);

    localparam int DEST_POS = LEN_LSB + LEN_W;

    state_t            state, state_next;
    logic [1:0]        dest_q;
    logic [LEN_W-1:0]  remaining;
    logic [CNT_W-1:0]  drop_cnt;

    logic [LEN_W-1:0]  hdr_len;
    logic [1:0]        hdr_dest;
    logic [1:0]        cur_dest;
    logic              take;
    logic              out_load, fwd_load;
    logic              out_accept, fwd_accept;
    logic              out_valid, fwd_valid;

    assign hdr_len   = in_enq_v[LEN_LSB +: LEN_W];
    assign hdr_dest  = in_enq_v[DEST_POS +: DEST_W];
    assign take      = in_enq__ENA && in_enq__RDY;
    assign dropCount = drop_cnt;
    assign dbg_state = state;

    // Ready by state, and steering of an accepted beat into its slot.
    always_comb begin
        in_enq__RDY = 1'b0;
        cur_dest    = dest_q;
        out_load    = 1'b0;
        fwd_load    = 1'b0;
        case (state)
            HDR: begin
                in_enq__RDY = out_accept && fwd_accept;
                cur_dest    = hdr_dest;
            end
            BODY: in_enq__RDY = (dest_q == DEST_OUT) ? out_accept : fwd_accept;
            DROP: in_enq__RDY = 1'b1;
            default: in_enq__RDY = 1'b0;
        endcase
        if (take && state != DROP) begin
            out_load = (cur_dest == DEST_OUT);
            fwd_load = (cur_dest == DEST_FWD);
        end
    end

    // Next-state: a nonzero-length header opens a packet, the last body beat closes it.
    always_comb begin
        state_next = state;
        if (take) begin
            case (state)
                HDR: begin
                    if (hdr_len != '0)
                        state_next = is_drop(hdr_dest) ? DROP : BODY;
                end
                BODY, DROP: begin
                    if (remaining == LEN_W'(1))
                        state_next = HDR;
                end
                default: state_next = HDR;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= HDR;
        else     state <= state_next;
    end

    // Packet bookkeeping: latched destination, body countdown, saturating drop count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dest_q    <= DEST_OUT;
            remaining <= '0;
            drop_cnt  <= '0;
        end else if (take) begin
            if (state == HDR) begin
                dest_q    <= hdr_dest;
                remaining <= hdr_len;
                if (is_drop(hdr_dest) && drop_cnt != '1)
                    drop_cnt <= drop_cnt + CNT_W'(1);
            end else if (remaining != '0) begin
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    demux_slot #(.DATA_W(DATA_W)) u_out_slot (
        .clk       (CLK),
        .rst       (RST),
        .load      (out_load),
        .load_data (in_enq_v),
        .accept    (out_accept),
        .valid     (out_valid),
        .data      (out_enq_v),
        .deq       (out_enq__RDY)
    );

    demux_slot #(.DATA_W(DATA_W)) u_fwd_slot (
        .clk       (CLK),
        .rst       (RST),
        .load      (fwd_load),
        .load_data (in_enq_v),
        .accept    (fwd_accept),
        .valid     (fwd_valid),
        .data      (forward_enq_v),
        .deq       (forward_enq__RDY)
    );

    assign out_enq__ENA     = out_valid && out_enq__RDY;
    assign forward_enq__ENA = fwd_valid && forward_enq__RDY;

endmodule

// File: tb/tb_demux_pipe.sv
// Bench for demux_pipe: directed packet scenarios plus a randomized packet
// stream checked against a per-destination packet model.
module tb_demux_pipe;
    import demux_pipe_pkg::*;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         in_ena = 1'b0;
    logic [127:0] in_v = '0;
    logic         in_rdy;
    logic         out_ena, fwd_ena;
    logic [127:0] out_v, fwd_v;
    logic         out_rdy = 1'b1;
    logic         fwd_rdy = 1'b1;
    logic [15:0]  drop_count;
    logic [1:0]   dbg_state;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;

    logic [127:0] got_out[$], got_fwd[$], exp_out[$], exp_fwd[$], stim_q[$];
    int           got_out_cyc[$], got_fwd_cyc[$];

    demux_pipe dut (
        .CLK              (CLK),
        .RST              (RST),
        .in_enq__ENA      (in_ena),
        .in_enq_v         (in_v),
        .in_enq__RDY      (in_rdy),
        .out_enq__ENA     (out_ena),
        .out_enq_v        (out_v),
        .out_enq__RDY     (out_rdy),
        .forward_enq__ENA (fwd_ena),
        .forward_enq_v    (fwd_v),
        .forward_enq__RDY (fwd_rdy),
        .dropCount        (drop_count),
        .dbg_state        (dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // Record every beat handed to a consumer, sampled mid-cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            if (out_ena) begin
                got_out.push_back(out_v);
                got_out_cyc.push_back(cyc);
            end
            if (fwd_ena) begin
                got_fwd.push_back(fwd_v);
                got_fwd_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] mk_hdr(input logic [1:0] dest, input logic [15:0] len);
        logic [127:0] h;
        h = rnd128();
        h[LEN_LSB +: 16] = len;
        h[DEST_LSB +: 2] = dest;
        return h;
    endfunction

    // driver tasks
    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_seen();
        got_out.delete();
        got_fwd.delete();
        got_out_cyc.delete();
        got_fwd_cyc.delete();
    endtask

    task automatic do_reset();
        next();
        RST = 1'b1;
        in_ena = 1'b0;
        out_rdy = 1'b1;
        fwd_rdy = 1'b1;
        next();
        RST = 1'b0;
        clear_seen();
    endtask

    // Push stim_q into the DUT, offering a beat only while in_rdy is high.
    task automatic send_stream(input int opct, input int fpct);
        int waited;
        waited = 0;
        while (stim_q.size() > 0) begin
            out_rdy = ($urandom_range(0, 99) < opct);
            fwd_rdy = ($urandom_range(0, 99) < fpct);
            #1;
            if (in_rdy) begin
                in_ena = 1'b1;
                in_v = stim_q.pop_front();
                waited = 0;
            end else begin
                in_ena = 1'b0;
                waited++;
                if (waited > 200) begin
                    tests_run++;
                    fails++;
                    $display("FAIL stream_timeout: in_rdy low for %0d cycles, required to rise", waited);
                    stim_q.delete();
                end
            end
            next();
        end
        in_ena = 1'b0;
        out_rdy = 1'b1;
        fwd_rdy = 1'b1;
        repeat (4) next();
    endtask

    // tests
    task automatic test_reset();
        do_reset();
        tests_run++;
        if (out_ena !== 1'b0 || fwd_ena !== 1'b0) begin
            fails++;
            $display("FAIL reset_ena: got out=%b fwd=%b required 0 0", out_ena, fwd_ena);
        end
        tests_run++;
        if (out_v !== '0 || fwd_v !== '0) begin
            fails++;
            $display("FAIL reset_data: got out=%h fwd=%h required 0", out_v, fwd_v);
        end
        tests_run++;
        if (drop_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_drop: got %0d required 0", drop_count);
        end
        tests_run++;
        if (in_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_rdy: got %b required 1", in_rdy);
        end
        tests_run++;
        if (dbg_state !== HDR) begin
            fails++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, HDR);
        end
    endtask

    task automatic test_basic();
        logic [127:0] beats[3];
        int c0;
        do_reset();
        beats[0] = mk_hdr(DEST_OUT, 16'd2);
        beats[1] = rnd128();
        beats[2] = rnd128();
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            in_ena = 1'b1;
            in_v = beats[i];
            next();
        end
        in_ena = 1'b0;
        repeat (3) next();
        tests_run++;
        if (got_out.size() != 3 || got_fwd.size() != 0) begin
            fails++;
            $display("FAIL basic_count: got out=%0d fwd=%0d required 3 0", got_out.size(), got_fwd.size());
        end
        for (int i = 0; i < 3 && i < got_out.size(); i++) begin
            tests_run++;
            if (got_out[i] !== beats[i] || got_out_cyc[i] - c0 != i + 1) begin
                fails++;
                $display("FAIL basic_beat[%0d]: got %h at cycle %0d required %h at cycle %0d",
                         i, got_out[i], got_out_cyc[i] - c0, beats[i], i + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] h1, h2;
        int c0;
        do_reset();
        h1 = mk_hdr(DEST_FWD, 16'd0);
        h2 = mk_hdr(DEST_OUT, 16'd0);
        c0 = cyc;
        in_ena = 1'b1;
        in_v = h1;
        next();
        in_v = h2;
        next();
        in_ena = 1'b0;
        repeat (3) next();
        tests_run++;
        if (got_fwd.size() != 1 || got_fwd[0] !== h1 || got_fwd_cyc[0] - c0 != 1) begin
            fails++;
            $display("FAIL b2b_fwd: got %0d beats first %h required 1 beat %h at cycle 1",
                     got_fwd.size(), got_fwd[0], h1);
        end
        tests_run++;
        if (got_out.size() != 1 || got_out[0] !== h2 || got_out_cyc[0] - c0 != 2) begin
            fails++;
            $display("FAIL b2b_out: got %0d beats first %h required 1 beat %h at cycle 2",
                     got_out.size(), got_out[0], h2);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp[4];
        do_reset();
        fwd_rdy = 1'b0;
        exp[0] = mk_hdr(DEST_FWD, 16'd3);
        for (int i = 1; i < 4; i++) exp[i] = rnd128();
        in_ena = 1'b1;
        in_v = exp[0];
        next();
        in_ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (in_rdy !== 1'b0 || fwd_ena !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall[%0d]: got rdy=%b fwd_ena=%b required 0 0", i, in_rdy, fwd_ena);
            end
            next();
        end
        for (int i = 1; i < 4; i++) stim_q.push_back(exp[i]);
        send_stream(100, 100);
        tests_run++;
        if (got_fwd.size() != 4 || got_out.size() != 0) begin
            fails++;
            $display("FAIL bp_count: got fwd=%0d out=%0d required 4 0", got_fwd.size(), got_out.size());
        end
        for (int i = 0; i < 4 && i < got_fwd.size(); i++) begin
            tests_run++;
            if (got_fwd[i] !== exp[i]) begin
                fails++;
                $display("FAIL bp_beat[%0d]: got %h required %h", i, got_fwd[i], exp[i]);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        out_rdy = 1'b0;
        fwd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (in_rdy !== 1'b1) begin
                fails++;
                $display("FAIL drop_rdy[%0d]: got %b required 1", i, in_rdy);
            end
            in_ena = 1'b1;
            in_v = (i == 0) ? mk_hdr(DEST_DROP, 16'd3) : rnd128();
            next();
        end
        in_ena = 1'b0;
        out_rdy = 1'b1;
        fwd_rdy = 1'b1;
        repeat (3) next();
        tests_run++;
        if (got_out.size() != 0 || got_fwd.size() != 0) begin
            fails++;
            $display("FAIL drop_emit: got out=%0d fwd=%0d required 0 0", got_out.size(), got_fwd.size());
        end
        tests_run++;
        if (drop_count !== 16'd1) begin
            fails++;
            $display("FAIL drop_count: got %0d required 1", drop_count);
        end
    endtask

    task automatic test_mid_reset();
        logic [127:0] h2;
        int c0;
        do_reset();
        in_ena = 1'b1;
        in_v = mk_hdr(DEST_OUT, 16'd3);
        next();
        in_v = rnd128();
        next();
        in_ena = 1'b0;
        out_rdy = 1'b0;
        RST = 1'b1;
        next();
        RST = 1'b0;
        out_rdy = 1'b1;
        fwd_rdy = 1'b1;
        #1;
        tests_run++;
        if (out_ena !== 1'b0 || fwd_ena !== 1'b0 || out_v !== '0 || fwd_v !== '0) begin
            fails++;
            $display("FAIL midrst_slots: got ena=%b%b out=%h fwd=%h required empty", out_ena, fwd_ena, out_v, fwd_v);
        end
        tests_run++;
        if (dbg_state !== HDR || in_rdy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_state: got state=%0d rdy=%b required %0d 1", dbg_state, in_rdy, HDR);
        end
        clear_seen();
        h2 = mk_hdr(DEST_FWD, 16'd0);
        c0 = cyc;
        in_ena = 1'b1;
        in_v = h2;
        next();
        in_ena = 1'b0;
        repeat (3) next();
        tests_run++;
        if (got_fwd.size() != 1 || got_fwd[0] !== h2 || got_fwd_cyc[0] - c0 != 1 || got_out.size() != 0) begin
            fails++;
            $display("FAIL midrst_next: got fwd=%0d out=%0d first %h required one fwd beat %h",
                     got_fwd.size(), got_out.size(), got_fwd[0], h2);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        in_ena = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_v = mk_hdr(2'($urandom_range(2, 3)), 16'd0);
            next();
        end
        in_ena = 1'b0;
        #1;
        tests_run++;
        if (drop_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL sat_reach: got %h required ffff", drop_count);
        end
        stim_q.push_back(mk_hdr(DEST_DROP, 16'd2));
        stim_q.push_back(rnd128());
        stim_q.push_back(rnd128());
        send_stream(100, 100);
        tests_run++;
        if (drop_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL sat_hold: got %h required ffff", drop_count);
        end
        tests_run++;
        if (got_out.size() != 0 || got_fwd.size() != 0) begin
            fails++;
            $display("FAIL sat_emit: got out=%0d fwd=%0d required 0 0", got_out.size(), got_fwd.size());
        end
    endtask

    // Random packets with random consumer stalls; the model just sorts whole
    // packets into per-destination queues and counts discarded ones.
    task automatic test_random(input int opct, input int fpct);
        int exp_drop;
        logic [1:0] dest;
        logic [15:0] len;
        logic [127:0] beat;
        do_reset();
        exp_out.delete();
        exp_fwd.delete();
        exp_drop = 0;
        for (int p = 0; p < 40; p++) begin
            dest = 2'($urandom_range(0, 3));
            len = 16'($urandom_range(0, 4));
            for (int b = 0; b <= int'(len); b++) begin
                beat = (b == 0) ? mk_hdr(dest, len) : rnd128();
                stim_q.push_back(beat);
                if (dest == DEST_OUT) exp_out.push_back(beat);
                else if (dest == DEST_FWD) exp_fwd.push_back(beat);
            end
            if (dest >= DEST_DROP) exp_drop++;
        end
        send_stream(opct, fpct);
        tests_run++;
        if (got_out.size() != exp_out.size() || got_fwd.size() != exp_fwd.size()) begin
            fails++;
            $display("FAIL rand_count: got out=%0d fwd=%0d required %0d %0d",
                     got_out.size(), got_fwd.size(), exp_out.size(), exp_fwd.size());
        end
        for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
            tests_run++;
            if (got_out[i] !== exp_out[i]) begin
                fails++;
                $display("FAIL rand_out[%0d]: got %h required %h", i, got_out[i], exp_out[i]);
            end
        end
        for (int i = 0; i < exp_fwd.size() && i < got_fwd.size(); i++) begin
            tests_run++;
            if (got_fwd[i] !== exp_fwd[i]) begin
                fails++;
                $display("FAIL rand_fwd[%0d]: got %h required %h", i, got_fwd[i], exp_fwd[i]);
            end
        end
        tests_run++;
        if (drop_count !== 16'(exp_drop)) begin
            fails++;
            $display("FAIL rand_drop: got %0d required %0d", drop_count, exp_drop);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_drop();
        test_mid_reset();
        test_random(100, 100);
        test_random(60, 75);
        test_random(30, 50);
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
